login_sequencer: RTL and testbench

Session controller that sequences the password-check FSM for the Braille Script Trainer. It takes a user-ID entry and restarts the checker for that user. It waits for the checker's verdict, then opens a session, counts failed attempts and enforces a timed lockout after too many failures. It sits between the keypad/user-select front end and the password checker, and owns the checker's active-low restart and start strobe.

---
 rtl/login_sequencer.sv | 122 ++++++++++++
 tb/tb_login_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/login_sequencer.sv
// rtl/login_sequencer.sv - login session sequencer with failed-attempt lockout for the password checker
module login_sequencer #(
  parameter int                 MAX_TRIES   = 3,
  parameter int                 CNT_W       = 24,
  parameter logic [CNT_W-1:0]   LOCK_CYCLES = 24'd12_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       user_valid,
  input  logic [2:0] user_id,
  input  logic       logout,
  input  logic       chk_allow,
  input  logic       chk_wrong,
  output logic       chk_rst_n,
  output logic       chk_pass_allow,
  output logic [2:0] chk_user,
  output logic       session_active,
  output logic [2:0] session_user,
  output logic       locked,
  output logic [1:0] fail_count,
  output logic       login_ok,
  output logic       login_fail,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_SESSION = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  localparam logic [1:0] MAX_F = 2'(MAX_TRIES);

  state_t           state;
  logic [CNT_W-1:0] lock_cnt;
  logic [1:0]       fail_next;

  // Failure count after the attempt currently being judged
  assign fail_next = fail_count + 2'd1;

  // Session FSM; every output is registered alongside the state transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      lock_cnt       <= '0;
      chk_rst_n      <= 1'b0;
      chk_pass_allow <= 1'b0;
      chk_user       <= 3'd0;
      session_active <= 1'b0;
      session_user   <= 3'd0;
      locked         <= 1'b0;
      fail_count     <= 2'd0;
      login_ok       <= 1'b0;
      login_fail     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      login_ok   <= 1'b0;
      login_fail <= 1'b0;
      case (state)
        S_IDLE: begin
          if (user_valid) begin
            chk_user       <= user_id;
            session_user   <= user_id;
            chk_rst_n      <= 1'b1;
            chk_pass_allow <= 1'b1;
            busy           <= 1'b1;
            state          <= S_START;
          end
        end
        S_START: begin
          // The checker has sampled the strobe; keep it out of restart while waiting
          chk_pass_allow <= 1'b0;
          state          <= S_WAIT;
        end
        S_WAIT: begin
          // A wrong verdict wins over a simultaneous allow
          if (chk_wrong) begin
            fail_count <= fail_next;
            login_fail <= 1'b1;
            chk_rst_n  <= 1'b0;
            busy       <= 1'b0;
            if (fail_next == MAX_F) begin
              locked   <= 1'b1;
              lock_cnt <= LOCK_CYCLES - 1'b1;
              state    <= S_LOCKOUT;
            end else begin
              state    <= S_IDLE;
            end
          end else if (chk_allow) begin
            fail_count     <= 2'd0;
            login_ok       <= 1'b1;
            session_active <= 1'b1;
            chk_rst_n      <= 1'b0;
            busy           <= 1'b0;
            state          <= S_SESSION;
          end
        end
        S_SESSION: begin
          if (logout) begin
            session_active <= 1'b0;
            state          <= S_IDLE;
          end
        end
        S_LOCKOUT: begin
          if (lock_cnt == '0) begin
            locked     <= 1'b0;
            fail_count <= 2'd0;
            state      <= S_IDLE;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_login_sequencer.sv
// tb/tb_login_sequencer.sv - directed self-checking bench for login_sequencer
module tb_login_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       user_valid;
  logic [2:0] user_id;
  logic       logout;
  logic       chk_allow;
  logic       chk_wrong;
  logic       chk_rst_n;
  logic       chk_pass_allow;
  logic [2:0] chk_user;
  logic       session_active;
  logic [2:0] session_user;
  logic       locked;
  logic [1:0] fail_count;
  logic       login_ok;
  logic       login_fail;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  login_sequencer #(
    .MAX_TRIES  (3),
    .CNT_W      (24),
    .LOCK_CYCLES(24'd8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .user_valid    (user_valid),
    .user_id       (user_id),
    .logout        (logout),
    .chk_allow     (chk_allow),
    .chk_wrong     (chk_wrong),
    .chk_rst_n     (chk_rst_n),
    .chk_pass_allow(chk_pass_allow),
    .chk_user      (chk_user),
    .session_active(session_active),
    .session_user  (session_user),
    .locked        (locked),
    .fail_count    (fail_count),
    .login_ok      (login_ok),
    .login_fail    (login_fail),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request a login; returns with the sequencer in WAIT
  task automatic start_login(input logic [2:0] uid);
    user_id    = uid;
    user_valid = 1'b1;
    step();
    user_valid = 1'b0;
    step();
  endtask

  // Present a verdict for exactly one sampling edge
  task automatic verdict(input logic a, input logic w);
    chk_allow = a;
    chk_wrong = w;
    step();
    chk_allow = 1'b0;
    chk_wrong = 1'b0;
  endtask

  function automatic logic [14:0] all_out();
    return {chk_rst_n, chk_pass_allow, chk_user, session_active, session_user,
            locked, fail_count, login_ok, login_fail, busy};
  endfunction

  initial begin
    rst = 1'b1; user_valid = 1'b0; user_id = 3'd0; logout = 1'b0;
    chk_allow = 1'b0; chk_wrong = 1'b0;
    step(); step();
    rst = 1'b0;
    check("reset_outputs", 32'(all_out()), 32'h0);

    // chk_allow in IDLE is ignored
    chk_allow = 1'b1;
    step();
    check("idle_allow_busy", 32'(busy), 32'd0);
    check("idle_allow_ok", 32'(login_ok), 32'd0);
    check("idle_allow_sess", 32'(session_active), 32'd0);

    // Start user 5; chk_allow stays high through START and must be ignored
    user_id = 3'd5; user_valid = 1'b1;
    step();
    user_valid = 1'b0;
    check("start_user", 32'(chk_user), 32'd5);
    check("start_strobe", 32'(chk_pass_allow), 32'd1);
    check("start_rstn", 32'(chk_rst_n), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    step();
    chk_allow = 1'b0;
    check("wait_strobe", 32'(chk_pass_allow), 32'd0);
    check("wait_busy", 32'(busy), 32'd1);
    check("start_allow_ignored", 32'(session_active), 32'd0);

    // logout in WAIT is ignored
    logout = 1'b1;
    step();
    logout = 1'b0;
    check("wait_logout_busy", 32'(busy), 32'd1);
    check("wait_rstn", 32'(chk_rst_n), 32'd1);

    // Good login
    verdict(1'b1, 1'b0);
    check("good_ok", 32'(login_ok), 32'd1);
    check("good_sess", 32'(session_active), 32'd1);
    check("good_suser", 32'(session_user), 32'd5);
    check("good_fail", 32'(fail_count), 32'd0);
    check("good_rstn", 32'(chk_rst_n), 32'd0);
    step();
    check("good_ok_pulse", 32'(login_ok), 32'd0);

    // user_valid in SESSION is ignored
    user_id = 3'd2; user_valid = 1'b1;
    step();
    user_valid = 1'b0;
    check("sess_uv_strobe", 32'(chk_pass_allow), 32'd0);
    check("sess_uv_user", 32'(chk_user), 32'd5);
    check("sess_uv_active", 32'(session_active), 32'd1);

    logout = 1'b1;
    step();
    logout = 1'b0;
    check("logout_sess", 32'(session_active), 32'd0);
    check("logout_suser", 32'(session_user), 32'd5);

    // Single failure then a good login clears the count
    start_login(3'd3);
    verdict(1'b0, 1'b1);
    check("fail1_pulse", 32'(login_fail), 32'd1);
    check("fail1_count", 32'(fail_count), 32'd1);
    check("fail1_locked", 32'(locked), 32'd0);
    check("fail1_busy", 32'(busy), 32'd0);
    step();
    check("fail1_pulse_end", 32'(login_fail), 32'd0);
    start_login(3'd3);
    verdict(1'b1, 1'b0);
    check("fail1_clear", 32'(fail_count), 32'd0);
    logout = 1'b1;
    step();
    logout = 1'b0;

    // Simultaneous verdict counts as wrong
    start_login(3'd1);
    verdict(1'b1, 1'b1);
    check("both_fail", 32'(login_fail), 32'd1);
    check("both_ok", 32'(login_ok), 32'd0);
    check("both_count", 32'(fail_count), 32'd1);
    check("both_sess", 32'(session_active), 32'd0);

    // Two more failures reach MAX_TRIES and lock out for 8 cycles
    start_login(3'd1);
    verdict(1'b0, 1'b1);
    check("fail2_count", 32'(fail_count), 32'd2);
    check("fail2_locked", 32'(locked), 32'd0);
    start_login(3'd1);
    verdict(1'b0, 1'b1);
    check("lock_count", 32'(fail_count), 32'd3);
    check("lock_locked", 32'(locked), 32'd1);
    user_id = 3'd6; user_valid = 1'b1;
    step();
    user_valid = 1'b0;
    check("lock_uv_strobe", 32'(chk_pass_allow), 32'd0);
    check("lock_uv_user", 32'(chk_user), 32'd1);
    for (int i = 0; i < 6; i++) step();
    check("lock_m7_locked", 32'(locked), 32'd1);
    check("lock_m7_count", 32'(fail_count), 32'd3);
    step();
    check("lock_end_locked", 32'(locked), 32'd0);
    check("lock_end_count", 32'(fail_count), 32'd0);

    // Reset held two cycles mid-WAIT
    start_login(3'd4);
    check("prerst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("midrst_outputs", 32'(all_out()), 32'h0);
    start_login(3'd7);
    check("postrst_user", 32'(chk_user), 32'd7);
    check("postrst_busy", 32'(busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
